// File: rtl/seq_gesture_pkg.sv
// Shared constants, pulse-cause enum and helpers for the sequence-gesture controller.
package seq_gesture_pkg;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_DB_CYCLES      = 5;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam bit DEF_STRICT         = 1'b1;

    // Widest channel count the onehot helper can decode.
    localparam int MAX_CH = 32;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_DONE,
        EV_ERR,
        EV_TMO
    } ev_cause_e;

    function automatic int step_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

    function automatic logic [MAX_CH-1:0] onehot(input int idx);
        return {{(MAX_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/seq_gesture_ctrl_if.sv
// Sensor-side bundle: raw channel levels in, step indication and pulses out.
interface seq_gesture_ctrl_if
    import seq_gesture_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    localparam int STEP_W = step_width(N_CH);

    logic [N_CH-1:0]   sw;
    logic [N_CH-1:0]   led;
    logic [STEP_W-1:0] step;
    logic [N_CH-1:0]   stable_sw;
    logic              done;
    logic              err;
    logic              tmo;

    modport master (
        output sw,
        input  led, step, stable_sw, done, err, tmo
    );

    modport slave (
        input  sw,
        output led, step, stable_sw, done, err, tmo
    );

endinterface

// File: rtl/sw_debounce.sv
// Single-channel debouncer: a raw level must differ from the accepted level
// for DB_CYCLES consecutive samples before it is taken.
module sw_debounce #(
    parameter int DB_CYCLES = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_gesture_ctrl.sv
// Sequence-gesture controller: debounced channels drive an ordered step FSM
// with idle timeout and one-cycle done/err/tmo pulses.
//
// state          | meaning
// S_0            | idle, waiting for channel 0
// S_k, 0<k<N-1   | channels 0..k-1 seen in order, waiting for channel k
// S_{N_CH-1}     | waiting for last channel; hit wraps to S_0 with done
module seq_gesture_ctrl
    import seq_gesture_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int DB_CYCLES      = DEF_DB_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter bit STRICT         = DEF_STRICT
) (
    input logic               clk,
    input logic               reset,
    seq_gesture_ctrl_if.slave bus
);
    localparam int STEP_W = step_width(N_CH);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_CH - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [N_CH-1:0]   stable_sw;
    logic [N_CH-1:0]   prev_sw;
    logic [N_CH-1:0]   exp_sw;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDLE_W-1:0] idle_q;
    logic              event_hit;
    logic              timeout_hit;
    logic              done_q, err_q, tmo_q;
    ev_cause_e         cause;

    for (genvar i = 0; i < N_CH; i++) begin : g_db
        sw_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.sw[i]),
            .stable (stable_sw[i])
        );
    end

    // Release to all-zero is never an event, only a fresh non-zero pattern.
    assign event_hit   = (stable_sw != prev_sw) && (stable_sw != '0);
    assign exp_sw      = N_CH'(onehot(int'(step_q)));
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (step_q != '0) && (idle_q == IDLE_LAST);

    always_comb begin
        step_d = step_q;
        cause  = EV_NONE;
        if (event_hit && (stable_sw == exp_sw)) begin
            if (step_q == LAST_STEP) begin
                step_d = '0;
                cause  = EV_DONE;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end else if (event_hit && STRICT) begin
            step_d = '0;
            cause  = EV_ERR;
        end else if (timeout_hit) begin
            step_d = '0;
            cause  = EV_TMO;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q  <= '0;
            prev_sw <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            step_q  <= step_d;
            prev_sw <= stable_sw;
            done_q  <= (cause == EV_DONE);
            err_q   <= (cause == EV_ERR);
            tmo_q   <= (cause == EV_TMO);
            if ((step_d != step_q) || (step_q == '0) || (TIMEOUT_CYCLES == 0)) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + IDLE_W'(1);
            end
        end
    end

    assign bus.step      = step_q;
    assign bus.led       = N_CH'(onehot(int'(step_q)));
    assign bus.stable_sw = stable_sw;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.tmo       = tmo_q;

endmodule

// File: tb/tb_seq_gesture_ctrl.sv
// Bench for seq_gesture_ctrl: strict and lenient instances share one stimulus
// stream and are compared every cycle against a sample-history reference model.
module tb_seq_gesture_ctrl;
    import seq_gesture_pkg::*;

    localparam int N  = 4;
    localparam int DB = 5;
    localparam int TO = 20;

    logic         clk;
    logic         reset;
    logic [N-1:0] sw;

    seq_gesture_ctrl_if #(.N_CH(N)) ifs ();
    seq_gesture_ctrl_if #(.N_CH(N)) ifn ();

    assign ifs.sw = sw;
    assign ifn.sw = sw;

    seq_gesture_ctrl #(
        .N_CH(N), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO), .STRICT(1'b1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs.slave)
    );

    seq_gesture_ctrl #(
        .N_CH(N), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO), .STRICT(1'b0)
    ) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (ifn.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is the strict instance, index 1 the lenient one.
    // A channel flips once its last DB samples all disagree with the accepted level;
    // the timeout fires TO edges after the most recent step change.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_stable, m_prev;
    int           m_step[2];
    int           m_last[2];
    ev_cause_e    m_cause[2];
    int           edge_n;
    bit           m_ev;
    bit           m_flip;
    int           m_ns;
    logic [N-1:0] m_tgt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_stable = '0;
            m_prev   = '0;
            edge_n   = 0;
            for (int k = 0; k < 2; k++) begin
                m_step[k]  = 0;
                m_last[k]  = 0;
                m_cause[k] = EV_NONE;
            end
        end else begin
            edge_n++;
            m_ev = (m_stable != m_prev) && (m_stable != '0);
            for (int k = 0; k < 2; k++) begin
                m_cause[k] = EV_NONE;
                m_ns       = m_step[k];
                m_tgt      = '0;
                m_tgt[m_step[k]] = 1'b1;
                if (m_ev && m_stable == m_tgt) begin
                    m_ns = (m_step[k] + 1) % N;
                    if (m_step[k] == N - 1) m_cause[k] = EV_DONE;
                end else if (m_ev && k == 0) begin
                    m_ns       = 0;
                    m_cause[k] = EV_ERR;
                end else if (m_step[k] != 0 && (edge_n - m_last[k]) == TO) begin
                    m_ns       = 0;
                    m_cause[k] = EV_TMO;
                end
                if (m_ns != m_step[k]) m_last[k] = edge_n;
                m_step[k] = m_ns;
            end
            m_prev = m_stable;
            hist.push_back(sw);
            if (hist.size() > DB) void'(hist.pop_front());
            if (hist.size() == DB) begin
                for (int c = 0; c < N; c++) begin
                    m_flip = 1'b1;
                    for (int i = 0; i < DB; i++)
                        if (hist[i][c] == m_stable[c]) m_flip = 1'b0;
                    if (m_flip) m_stable[c] = ~m_stable[c];
                end
            end
        end
    end

    function automatic logic [31:0] model_vec(input int k);
        logic [N-1:0] l;
        l = '0;
        l[m_step[k]] = 1'b1;
        return 32'({2'(m_step[k]), l, m_stable,
                    m_cause[k] == EV_DONE, m_cause[k] == EV_ERR, m_cause[k] == EV_TMO});
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_strict",
                32'({ifs.step, ifs.led, ifs.stable_sw, ifs.done, ifs.err, ifs.tmo}), model_vec(0));
            chk("model_lenient",
                32'({ifn.step, ifn.led, ifn.stable_sw, ifn.done, ifn.err, ifn.tmo}), model_vec(1));
        end
    end

    int n_done[2], n_err[2], n_tmo[2];
    initial for (int k = 0; k < 2; k++) begin n_done[k] = 0; n_err[k] = 0; n_tmo[k] = 0; end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (ifs.done) n_done[0]++;
            if (ifs.err)  n_err[0]++;
            if (ifs.tmo)  n_tmo[0]++;
            if (ifn.done) n_done[1]++;
            if (ifn.err)  n_err[1]++;
            if (ifn.tmo)  n_tmo[1]++;
        end
    end

    function automatic int pulses(input int k);
        return n_done[k] + n_err[k] + n_tmo[k];
    endfunction

    task automatic hold(input logic [N-1:0] v, input int n);
        sw = v;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] sw;
        int           hold;
        logic [N-1:0] exp_led;
        logic [N-1:0] exp_stable;
        int           exp_pulses;
    } vec_t;

    vec_t tbl[6];
    int   base_s, base_n;
    logic [N-1:0] rv;

    initial begin
        tbl[0] = '{sw: 4'b0001, hold: 8, exp_led: 4'b0010, exp_stable: 4'b0001, exp_pulses: 0};
        tbl[1] = '{sw: 4'b0000, hold: 8, exp_led: 4'b0010, exp_stable: 4'b0000, exp_pulses: 0};
        tbl[2] = '{sw: 4'b0010, hold: 8, exp_led: 4'b0100, exp_stable: 4'b0010, exp_pulses: 0};
        tbl[3] = '{sw: 4'b0000, hold: 8, exp_led: 4'b0100, exp_stable: 4'b0000, exp_pulses: 0};
        tbl[4] = '{sw: 4'b0100, hold: 8, exp_led: 4'b1000, exp_stable: 4'b0100, exp_pulses: 0};
        tbl[5] = '{sw: 4'b0000, hold: 8, exp_led: 4'b1000, exp_stable: 4'b0000, exp_pulses: 0};

        reset = 1'b1;
        sw    = '0;
        repeat (3) @(negedge clk);
        chk("rst_step",   32'(ifs.step), 32'd0);
        chk("rst_led",    32'(ifs.led), 32'b0001);
        chk("rst_stable", 32'(ifs.stable_sw), 32'd0);
        chk("rst_pulses", 32'({ifs.done, ifs.err, ifs.tmo, ifn.done, ifn.err, ifn.tmo}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // In-order sequence
        base_s = pulses(0);
        for (int i = 0; i < 6; i++) begin
            hold(tbl[i].sw, tbl[i].hold);
            chk("tbl_led",     32'(ifs.led), 32'(tbl[i].exp_led));
            chk("tbl_led_len", 32'(ifn.led), 32'(tbl[i].exp_led));
            chk("tbl_stable",  32'(ifs.stable_sw), 32'(tbl[i].exp_stable));
            chk("tbl_pulses",  32'(pulses(0) - base_s), 32'(tbl[i].exp_pulses));
        end
        sw = 4'b1000;
        repeat (5) @(negedge clk);
        chk("done_early",  32'({ifs.done, ifs.step}), 32'({1'b0, 2'd3}));
        chk("done_stable", 32'(ifs.stable_sw), 32'b1000);
        @(negedge clk);
        chk("done_pulse",  32'({ifs.done, ifn.done, ifs.led}), 32'({2'b11, 4'b0001}));
        @(negedge clk);
        chk("done_single", 32'(ifs.done), 32'd0);
        hold(4'b0000, 8);
        chk("done_count", 32'(n_done[0] + pulses(0) - base_s - n_done[0]), 32'd1);

        // Glitch rejection
        base_s = pulses(0);
        hold(4'b0001, 4);
        hold(4'b0000, 8);
        chk("glitch_stable", 32'(ifs.stable_sw), 32'd0);
        chk("glitch_led",    32'(ifs.led), 32'b0001);
        chk("glitch_pulses", 32'(pulses(0) - base_s), 32'd0);
        hold(4'b0001, 5);
        chk("db5_stable", 32'(ifs.stable_sw), 32'b0001);
        chk("db5_led_pre", 32'(ifs.led), 32'b0001);
        hold(4'b0000, 1);
        chk("db5_led", 32'({ifs.led, ifn.led}), 32'({4'b0010, 4'b0010}));
        hold(4'b0000, 6);

        // Wrong order from step 1
        base_s = n_err[0];
        base_n = n_tmo[1];
        hold(4'b0100, 5);
        chk("wrong_pre", 32'(ifs.step), 32'd1);
        @(negedge clk);
        chk("wrong_strict",  32'({ifs.step, ifs.err}), 32'({2'd0, 1'b1}));
        chk("wrong_lenient", 32'({ifn.step, ifn.err}), 32'({2'd1, 1'b0}));
        hold(4'b0000, 25);
        chk("wrong_err_cnt",  32'(n_err[0] - base_s), 32'd1);
        chk("lenient_tmo",    32'({ifn.led, 4'(n_tmo[1] - base_n)}), 32'({4'b0001, 4'd1}));

        // Timeout exactly TO cycles after the step change
        base_s = n_tmo[0];
        hold(4'b0001, 8);
        hold(4'b0000, 8);
        hold(4'b0010, 6);
        chk("tmo_step2", 32'(ifs.step), 32'd2);
        hold(4'b0000, 19);
        chk("tmo_early", 32'({ifs.step, ifs.tmo}), 32'({2'd2, 1'b0}));
        @(negedge clk);
        chk("tmo_fire", 32'({ifs.tmo, ifn.tmo, ifs.led}), 32'({2'b11, 4'b0001}));
        @(negedge clk);
        chk("tmo_single", 32'(n_tmo[0] - base_s), 32'd1);

        // Valid event on the timeout cycle wins
        base_s = n_tmo[0];
        hold(4'b0001, 6);
        chk("race_step1", 32'(ifs.step), 32'd1);
        hold(4'b0000, 14);
        hold(4'b0010, 5);
        chk("race_pre", 32'({ifs.step, ifs.tmo}), 32'({2'd1, 1'b0}));
        @(negedge clk);
        chk("race_adv", 32'({ifs.step, ifs.tmo, ifn.step, ifn.tmo}), 32'({2'd2, 1'b0, 2'd2, 1'b0}));
        chk("race_tmo_cnt", 32'(n_tmo[0] - base_s), 32'd0);
        hold(4'b0000, 8);

        // Asynchronous reset mid-debounce at step 3
        hold(4'b0100, 8);
        hold(4'b0000, 8);
        chk("arst_step3", 32'(ifs.step), 32'd3);
        hold(4'b1000, 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_out", 32'({ifs.step, ifs.led, ifs.stable_sw, ifs.done, ifs.err, ifs.tmo}),
            32'({2'd0, 4'b0001, 4'b0000, 3'b000}));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold(4'b0001, 4);
        chk("arst_db4", 32'(ifs.stable_sw), 32'd0);
        @(negedge clk);
        chk("arst_db5", 32'({ifs.stable_sw, ifs.step}), 32'({4'b0001, 2'd0}));
        @(negedge clk);
        chk("arst_adv", 32'(ifs.led), 32'b0010);
        hold(4'b0000, 8);

        // Randomised patterns checked by the model every cycle
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      rv = '0;
            else if (r < 8) begin rv = '0; rv[$urandom_range(0, N - 1)] = 1'b1; end
            else            rv = N'($urandom);
            if (it == 40) begin
                @(negedge clk);
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            hold(rv, $urandom_range(1, 9));
        end
        hold(4'b0000, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gesture_ctrl.md
# seq_gesture_ctrl

Parametrised sequence-gesture controller for the assistive sensor front end. It debounces `N_CH` raw sensor/switch channels independently and walks a step FSM that advances only when the patient activates the expected channel in order. It drives one-hot step indication LEDs and emits single-cycle `done`, `err` and `tmo` pulses for the downstream command/actuator logic. This generalises the fixed 4-switch, 4-state controller with a configurable channel count, debounce length, timeout and strict-order mode.

## Interface
- `N_CH`, 4: sensor channels and FSM steps; legal range ≥2.
- `DB_CYCLES`, 5: consecutive cycles a raw change must persist before it is accepted; legal range ≥1.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in a non-zero step before the FSM falls back to step 0; 0 disables the timeout.
- `STRICT`, 1: 1 means a wrong non-zero input resets to step 0 and pulses `err`; 0 means wrong inputs are ignored.
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `sw` input `N_CH`: raw sensor levels, asynchronous to nothing (already synchronised upstream).
- `led` output `N_CH`: one-hot current step; bit `k` set means step `k`.
- `step` output `$clog2(N_CH)`: current step index.
- `stable_sw` output `N_CH`: debounced channel levels.
- `done` output 1: one-cycle pulse when the sequence completes (step `N_CH-1` → 0).
- `err` output 1: one-cycle pulse on a wrong input in strict mode.
- `tmo` output 1: one-cycle pulse on a timeout fallback.

## Operation
- **Reset values:** `step`=0, `led`=…0001, `stable_sw`=0, `done`/`err`/`tmo`=0, and all counters 0.
- **Debounce, per channel and independent:**
  - The counter clears whenever raw equals stable.
  - While raw ≠ stable, the counter increments.
  - On the edge where raw ≠ stable and the counter = `DB_CYCLES-1`, stable takes raw and the counter clears.
  - A glitch shorter than `DB_CYCLES` cycles never reaches `stable_sw`.
- **Event detect:** `prev_sw` registers `stable_sw`. An event is present in any cycle where `stable_sw ≠ prev_sw` and `stable_sw ≠ 0`. Transitions to all-zero (release) are never events.
- **FSM:** states `S_0` … `S_{N_CH-1}`, held as a binary `step`.
  - Event with `stable_sw == (1<<step)`: advance to `step+1`. From `N_CH-1` the FSM wraps to 0 and pulses `done`.
  - Event with any other non-zero pattern: if `STRICT`, go to step 0 and pulse `err` (even when already at step 0). Otherwise hold.
  - Timeout: the idle counter runs while `step ≠ 0`. It clears on any `step` change and is held at 0 while `step = 0`. When it reaches `TIMEOUT_CYCLES-1`, go to step 0, pulse `tmo` and clear the counter.
- **Simultaneous events:** a valid event outranks the timeout (advance, no `tmo`). A strict error outranks the timeout (`err` only). No more than one of `done`/`err`/`tmo` is high in any cycle.
- **Outputs:** `led` is decoded from registered `step`, so it is glitch-free.
- **Reset mid-operation:** all state, counters and pending pulses clear immediately and asynchronously. No pulse is emitted on reset release.

## Timing
- Raw change sampled at edge T (held steady) → `stable_sw` updates at edge T+`DB_CYCLES`-1 → `step`/`led`/pulse update at edge T+`DB_CYCLES`.
- End-to-end latency from first raw sample to LED change is `DB_CYCLES`+1 edges, counting the sampling edge.
- Pulses are high for exactly one cycle, aligned with the `step` update.
- Timeout fires `TIMEOUT_CYCLES` cycles after the last step change.
- Counter widths:
  - Debounce counter: `$clog2(DB_CYCLES+1)`.
  - Idle counter: `$clog2(TIMEOUT_CYCLES+1)`.
  - Arithmetic is unsigned and never wraps; saturation is not reachable by construction.

## Structure
- Shared package `seq_gesture_pkg` holds:
  - default parameter constants;
  - the `onehot(idx)` function;
  - the pulse-cause enum `{EV_NONE, EV_DONE, EV_ERR, EV_TMO}` used by the scoreboard.
- Sub-module `sw_debounce` is a single-bit channel with parameter `DB_CYCLES`, ports `clk`, `reset`, `raw` and `stable`. It is instantiated `N_CH` times via generate.
- The top holds event detect, the step FSM, the idle counter and output decode.

## Test plan
All scenarios use `N_CH`=4, `DB_CYCLES`=5, `TIMEOUT_CYCLES`=20, `STRICT`=1 unless stated.
- **In-order sequence:** `sw` = 0001, 0000, 0010, 0000, 0100, 0000, 1000, each held 8 cycles → `led` goes 0010, 0100, 1000, 0001. `done` pulses once, on the last transition, 6 edges after `sw`=1000 is applied.
- **Glitch rejection:** `sw`=0001 for 4 cycles, then 0000 → `stable_sw` stays 0000, `led` stays 0001, no pulses. The same input held 5 cycles → `led`=0010.
- **Wrong order:** from step 1, `sw`=0100 held 6 cycles → `step`=0 and one `err` pulse. Repeat with `STRICT`=0 → `step` stays 1 and no `err`.
- **Timeout:** advance to step 2, then hold `sw`=0 → `tmo` pulses exactly 20 cycles after the step change and `led`=0001. A correct event landing on the timeout cycle instead gives an advance with no `tmo`.
- **Asynchronous reset mid-debounce:** assert `reset` between clock edges at step 3, with the debounce counter at 3 → all outputs return to reset values before the next edge. After release, the first event needs a full 5 cycles of debounce.
